// File: rtl/ar_br_cr_pkg.sv
// Shared definitions for the AR/BR/CR sign-steered shift engine:
// controller state encoding and the path codes reported on op.
package ar_br_cr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] OP_CLR = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;

endpackage

// File: rtl/ar_br_cr_fsm.sv
// Sequencer for the shift engine: owns state, the shift counter and the
// busy/done handshake, and issues one-hot strobes to the datapath.
module ar_br_cr_fsm
  import ar_br_cr_pkg::*;
#(
  parameter int SHW = 3
) (
  input  logic           clk,
  input  logic           reset_b,
  input  logic           start,
  input  logic [SHW-1:0] sh_amt,
  input  logic           ar_neg,
  input  logic           ar_zero,
  input  logic           cnt_last,
  output logic [SHW-1:0] cnt,
  output logic           busy,
  output logic           done,
  output logic           load_ar_br,
  output logic           sel_div,
  output logic           sel_mul,
  output logic           clr_cr,
  output logic           shift_en
);

  state_e         state_q, state_d;
  logic [SHW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_ar_br = 1'b0;
    sel_div    = 1'b0;
    sel_mul    = 1'b0;
    clr_cr     = 1'b0;
    shift_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load_ar_br = 1'b1;
          cnt_d      = sh_amt;
          state_d    = EVAL;
        end
      end
      EVAL: begin
        // A zero AR short-circuits to DONE regardless of the shift count.
        if (ar_zero) begin
          clr_cr  = 1'b1;
          state_d = DONE;
        end else begin
          sel_div = ar_neg;
          sel_mul = !ar_neg;
          state_d = (cnt_q == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        cnt_d    = cnt_q - SHW'(1);
        if (cnt_last) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cnt  = cnt_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: rtl/ar_br_cr_engine.sv
// AR/BR/CR engine: AR<0 gives CR = AR >>> n, AR>0 gives CR = BR << n with
// overflow detect, AR==0 clears CR. One shift per clock under ar_br_cr_fsm.
module ar_br_cr_engine
  import ar_br_cr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic                    clk,
  input  logic                    reset_b,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] ar_in,
  input  logic        [WIDTH-1:0] br_in,
  input  logic        [SHW-1:0]   sh_amt,
  output logic                    busy,
  output logic                    done,
  output logic        [WIDTH-1:0] cr_out,
  output logic                    ovf,
  output logic        [1:0]       op
);

  logic signed [WIDTH-1:0] ar_q, ar_d;
  logic        [WIDTH-1:0] br_q, br_d;
  logic        [WIDTH-1:0] cr_q, cr_d;
  logic        [1:0]       op_q, op_d;
  logic                    ovf_q, ovf_d;

  logic           ar_neg, ar_zero, cnt_last;
  logic [SHW-1:0] cnt;
  logic           load_ar_br, sel_div, sel_mul, clr_cr, shift_en;

  // Arithmetic right shift by one: floor division by two.
  function automatic logic [WIDTH-1:0] shr_div(input logic [WIDTH-1:0] v);
    return {v[WIDTH-1], v[WIDTH-1:1]};
  endfunction

  function automatic logic [WIDTH-1:0] shl_mul(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], 1'b0};
  endfunction

  ar_br_cr_fsm #(
    .SHW(SHW)
  ) u_fsm (
    .clk       (clk),
    .reset_b   (reset_b),
    .start     (start),
    .sh_amt    (sh_amt),
    .ar_neg    (ar_neg),
    .ar_zero   (ar_zero),
    .cnt_last  (cnt_last),
    .cnt       (cnt),
    .busy      (busy),
    .done      (done),
    .load_ar_br(load_ar_br),
    .sel_div   (sel_div),
    .sel_mul   (sel_mul),
    .clr_cr    (clr_cr),
    .shift_en  (shift_en)
  );

  assign ar_neg   = ar_q[WIDTH-1];
  assign ar_zero  = (ar_q == '0);
  assign cnt_last = (cnt == SHW'(1));

  always_comb begin
    ar_d  = ar_q;
    br_d  = br_q;
    cr_d  = cr_q;
    op_d  = op_q;
    ovf_d = ovf_q;
    if (load_ar_br) begin
      ar_d  = ar_in;
      br_d  = br_in;
      ovf_d = 1'b0;
    end
    if (clr_cr) begin
      cr_d = '0;
      op_d = OP_CLR;
    end
    if (sel_div) begin
      cr_d = ar_q;
      op_d = OP_DIV;
    end
    if (sel_mul) begin
      cr_d = br_q;
      op_d = OP_MUL;
    end
    // Overflow is sticky: any 1 leaving the MSB during a multiply latches it.
    if (shift_en) begin
      if (op_q == OP_DIV) begin
        cr_d = shr_div(cr_q);
      end else if (op_q == OP_MUL) begin
        cr_d  = shl_mul(cr_q);
        ovf_d = ovf_q | cr_q[WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ar_q  <= '0;
      br_q  <= '0;
      cr_q  <= '0;
      op_q  <= OP_CLR;
      ovf_q <= 1'b0;
    end else begin
      ar_q  <= ar_d;
      br_q  <= br_d;
      cr_q  <= cr_d;
      op_q  <= op_d;
      ovf_q <= ovf_d;
    end
  end

  assign cr_out = cr_q;
  assign op     = op_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_ar_br_cr_engine.sv
// Bench for ar_br_cr_engine: directed vector table, hand-written corner
// sequences, and random operations against an arithmetic reference model.
module tb_ar_br_cr_engine;

  logic              clk;
  logic              reset_b;
  logic              start;
  logic signed [7:0] ar_in;
  logic        [7:0] br_in;
  logic        [2:0] sh_amt;
  logic              busy;
  logic              done;
  logic        [7:0] cr_out;
  logic              ovf;
  logic        [1:0] op;

  int n_assert = 0;
  int n_fail   = 0;

  ar_br_cr_engine #(
    .WIDTH(8),
    .SHW  (3)
  ) dut (
    .clk    (clk),
    .reset_b(reset_b),
    .start  (start),
    .ar_in  (ar_in),
    .br_in  (br_in),
    .sh_amt (sh_amt),
    .busy   (busy),
    .done   (done),
    .cr_out (cr_out),
    .ovf    (ovf),
    .op     (op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ar;
    logic [7:0] br;
    logic [2:0] n;
    logic [7:0] cr;
    logic [1:0] op;
    logic       ovf;
    int         lat;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: floor division for negative AR, modular product for positive.
  function automatic void model(input logic [7:0] ar, input logic [7:0] br, input logic [2:0] n,
                                output logic [7:0] cr, output logic [1:0] opc,
                                output logic ovfe, output int lat);
    int a, q, p, d;
    a = $signed(ar);
    d = 1 << n;
    if (a == 0) begin
      cr = 8'h00; opc = 2'b00; ovfe = 1'b0; lat = 2;
    end else if (a < 0) begin
      q = a / d;
      if (q * d != a) q = q - 1;
      cr = q[7:0]; opc = 2'b01; ovfe = 1'b0; lat = 2 + int'(n);
    end else begin
      p = int'(br) * d;
      cr = p[7:0]; opc = 2'b10; ovfe = (p > 255); lat = 2 + int'(n);
    end
  endfunction

  // Wait for done, counting post-edge samples from the start edge (start edge = 1).
  task automatic wait_done(inout int lat, inout logic busy_ok);
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      busy_ok &= busy;
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] n,
                        output logic [7:0] cr, output logic [1:0] opc, output logic ov,
                        output int lat, output logic busy_ok, output logic pulse_ok);
    @(negedge clk);
    ar_in = a; br_in = b; sh_amt = n; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    busy_ok = busy;
    wait_done(lat, busy_ok);
    cr = cr_out; opc = op; ov = ovf;
    @(posedge clk); #1;
    pulse_ok = !done && !busy && (cr_out == cr) && (op == opc) && (ovf == ov);
  endtask

  task automatic run_and_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic [2:0] n);
    logic [7:0] cr, ecr;
    logic [1:0] opc, eop;
    logic       ov, eov, bok, pok;
    int         lat, elat;
    model(a, b, n, ecr, eop, eov, elat);
    run_op(a, b, n, cr, opc, ov, lat, bok, pok);
    check({tag, " cr"}, cr, ecr);
    check({tag, " op"}, opc, eop);
    check({tag, " ovf"}, ov, eov);
    check({tag, " latency"}, lat, elat);
    check({tag, " busy"}, bok, 1'b1);
    check({tag, " done pulse"}, pok, 1'b1);
  endtask

  initial begin
    logic [7:0] cr, ra, rb;
    logic [1:0] opc;
    logic       ov, bok, pok;
    logic [2:0] rn;
    int         lat;

    tbl[0] = '{ar: 8'hF0, br: 8'h00, n: 3'd2, cr: 8'hFC, op: 2'b01, ovf: 1'b0, lat: 4};
    tbl[1] = '{ar: 8'h05, br: 8'h41, n: 3'd2, cr: 8'h04, op: 2'b10, ovf: 1'b1, lat: 4};
    tbl[2] = '{ar: 8'h00, br: 8'h55, n: 3'd5, cr: 8'h00, op: 2'b00, ovf: 1'b0, lat: 2};
    tbl[3] = '{ar: 8'h03, br: 8'h11, n: 3'd0, cr: 8'h11, op: 2'b10, ovf: 1'b0, lat: 2};
    tbl[4] = '{ar: 8'hFF, br: 8'h3C, n: 3'd7, cr: 8'hFF, op: 2'b01, ovf: 1'b0, lat: 9};
    tbl[5] = '{ar: 8'h7F, br: 8'hFF, n: 3'd7, cr: 8'h80, op: 2'b10, ovf: 1'b1, lat: 9};
    tbl[6] = '{ar: 8'h80, br: 8'h01, n: 3'd7, cr: 8'hFF, op: 2'b01, ovf: 1'b0, lat: 9};

    reset_b = 1'b0; start = 1'b0; ar_in = '0; br_in = '0; sh_amt = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset cr", cr_out, 8'h00);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset op", op, 2'b00);
    check("reset ovf", ovf, 1'b0);
    @(negedge clk); reset_b = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i].ar, tbl[i].br, tbl[i].n, cr, opc, ov, lat, bok, pok);
      check($sformatf("vec%0d cr", i), cr, tbl[i].cr);
      check($sformatf("vec%0d op", i), opc, tbl[i].op);
      check($sformatf("vec%0d ovf", i), ov, tbl[i].ovf);
      check($sformatf("vec%0d latency", i), lat, tbl[i].lat);
      check($sformatf("vec%0d busy", i), bok, 1'b1);
      check($sformatf("vec%0d done pulse", i), pok, 1'b1);
    end

    // A start pulse during SHIFT must be ignored and not queued.
    @(negedge clk);
    ar_in = 8'hF0; br_in = 8'h00; sh_amt = 3'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; lat = 1; bok = busy;
    repeat (2) begin @(posedge clk); #1; lat++; end
    ar_in = 8'h00; sh_amt = 3'd0; start = 1'b1;
    @(posedge clk); #1;
    lat++; start = 1'b0;
    wait_done(lat, bok);
    check("midshift cr", cr_out, 8'hFF);
    check("midshift op", op, 2'b01);
    check("midshift latency", lat, 7);
    @(posedge clk); #1;
    check("midshift no queue", busy, 1'b0);
    @(posedge clk); #1;
    check("midshift still idle", busy, 1'b0);

    // start held high retriggers after exactly one IDLE cycle.
    @(negedge clk);
    ar_in = 8'h03; br_in = 8'h11; sh_amt = 3'd0; start = 1'b1;
    @(posedge clk); #1;
    lat = 1; bok = busy;
    wait_done(lat, bok);
    check("held first latency", lat, 2);
    check("held first cr", cr_out, 8'h11);
    @(posedge clk); #1;
    check("held idle gap", busy, 1'b0);
    @(posedge clk); #1;
    check("held retrigger", busy, 1'b1);
    start = 1'b0; lat = 1;
    wait_done(lat, bok);
    check("held second latency", lat, 2);
    check("held second cr", cr_out, 8'h11);
    @(posedge clk); #1;

    // Asynchronous reset between edges during SHIFT.
    @(negedge clk);
    ar_in = 8'hFF; br_in = 8'h00; sh_amt = 3'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_b = 1'b0;
    #1;
    check("async rst cr", cr_out, 8'h00);
    check("async rst busy", busy, 1'b0);
    check("async rst done", done, 1'b0);
    check("async rst op", op, 2'b00);
    check("async rst ovf", ovf, 1'b0);
    @(negedge clk); reset_b = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check("post rst idle", busy, 1'b0);
    end
    run_and_check("post rst op", 8'h05, 8'h41, 3'd2);

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) ra = 8'h00;
      rb = 8'($urandom_range(0, 255));
      rn = 3'($urandom_range(0, 7));
      run_and_check($sformatf("rand%0d", i), ra, rb, rn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
